// File: rtl/adc_hex_formatter.sv
// adc_hex_formatter: turns each 16-bit ADS1115 result into the ASCII line "HHHH\r\n" for an 8N1 UART.
// Latency: sample accepted -> first o_tx_start 3 cycles later (UART idle); one byte per start/busy round trip.
// Backpressure: ready only in IDLE; valids offered while busy are dropped and counted (saturating).
// Optional feature macro ADC_HEX_CHAN_PREFIX_EN: prefix each line with "Cn=" (n = latched channel).

module adc_hex_formatter #(
    parameter int DROP_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [15:0]       i_sample,
    input  logic [1:0]        i_chan,
    input  logic              i_sample_valid,
    output logic              o_sample_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_busy,
    output logic [DROP_W-1:0] o_drop_cnt
);

`ifdef ADC_HEX_CHAN_PREFIX_EN
    // "Cn=" + four digits + CR + LF
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    // four digits + CR + LF
    localparam logic [3:0] LAST_IDX = 4'd5;
`endif

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_t;

    state_t      state;
    logic [3:0]  byte_idx;
    logic [15:0] sample_q;
    logic [7:0]  cur_byte;

`ifdef ADC_HEX_CHAN_PREFIX_EN
    logic [1:0]  chan_q;
`else
    // Channel only matters for the prefix; keep the port tied off without a holding register.
    logic        unused_chan;
    assign unused_chan = ^i_chan;
`endif

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // Select the byte of the current line addressed by byte_idx.
    always_comb begin
        cur_byte = 8'h00;
`ifdef ADC_HEX_CHAN_PREFIX_EN
        case (byte_idx)
            4'd0:    cur_byte = 8'h43;                    // 'C'
            4'd1:    cur_byte = 8'h30 + {6'b0, chan_q};   // '0'..'3'
            4'd2:    cur_byte = 8'h3D;                    // '='
            4'd3:    cur_byte = hex_ascii(sample_q[15:12]);
            4'd4:    cur_byte = hex_ascii(sample_q[11:8]);
            4'd5:    cur_byte = hex_ascii(sample_q[7:4]);
            4'd6:    cur_byte = hex_ascii(sample_q[3:0]);
            4'd7:    cur_byte = ASCII_CR;
            4'd8:    cur_byte = ASCII_LF;
            default: cur_byte = 8'h00;
        endcase
`else
        case (byte_idx)
            4'd0:    cur_byte = hex_ascii(sample_q[15:12]);
            4'd1:    cur_byte = hex_ascii(sample_q[11:8]);
            4'd2:    cur_byte = hex_ascii(sample_q[7:4]);
            4'd3:    cur_byte = hex_ascii(sample_q[3:0]);
            4'd4:    cur_byte = ASCII_CR;
            4'd5:    cur_byte = ASCII_LF;
            default: cur_byte = 8'h00;
        endcase
`endif
    end

    // Line sequencer: latch a sample, then walk its bytes through the UART start/busy handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            byte_idx       <= 4'd0;
            sample_q       <= 16'h0000;
            o_sample_ready <= 1'b0;
            o_tx_data      <= 8'h00;
            o_tx_start     <= 1'b0;
`ifdef ADC_HEX_CHAN_PREFIX_EN
            chan_q         <= 2'd0;
`endif
        end else begin
            // Start is a single-cycle pulse unless SEND fires this cycle.
            o_tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Ready comes up one cycle after reset or after the line finishes.
                    o_sample_ready <= 1'b1;
                    if (i_sample_valid && o_sample_ready) begin
                        sample_q       <= i_sample;
`ifdef ADC_HEX_CHAN_PREFIX_EN
                        chan_q         <= i_chan;
`endif
                        byte_idx       <= 4'd0;
                        o_sample_ready <= 1'b0;
                        state          <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Byte is presented here and stays put until the UART has finished it.
                    o_tx_data <= cur_byte;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (!i_tx_busy) begin
                        o_tx_start <= 1'b1;
                        state      <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    // Busy rising is the acknowledge; no timeout, a dead UART stalls here.
                    if (i_tx_busy) begin
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!i_tx_busy) begin
                        if (byte_idx == LAST_IDX) begin
                            o_sample_ready <= 1'b1;
                            state          <= ST_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            state    <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    o_sample_ready <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

    // Count samples offered while not ready; hold at all-ones rather than wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_drop_cnt <= '0;
        end else if (i_sample_valid && !o_sample_ready && (o_drop_cnt != {DROP_W{1'b1}})) begin
            o_drop_cnt <= o_drop_cnt + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_adc_hex_formatter.sv
// Bench for adc_hex_formatter: random samples against a string-table model of the ASCII line.
// Stimulus pushes expected bytes into a queue on acceptance; a monitor pops them on each o_tx_start.
// The monitor process also plays the UART: busy rises after an ack delay and falls after a hold time.

module tb_adc_hex_formatter;

`ifdef ADC_HEX_CHAN_PREFIX_EN
    localparam int LINE_LEN = 9;
`else
    localparam int LINE_LEN = 6;
`endif
    localparam int DROP_MAX = 255;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_sample = 16'h0000;
    logic [1:0]  i_chan = 2'd0;
    logic        i_sample_valid = 1'b0;
    logic        i_tx_busy = 1'b0;
    logic        o_sample_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic [7:0]  o_drop_cnt;

    always #5 i_clk = ~i_clk;

    adc_hex_formatter #(.DROP_W(8)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_sample       (i_sample),
        .i_chan         (i_chan),
        .i_sample_valid (i_sample_valid),
        .o_sample_ready (o_sample_ready),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .i_tx_busy      (i_tx_busy),
        .o_drop_cnt     (o_drop_cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int   drops = 0;
    int   start_cnt = 0;
    int   last_start_cyc = 0;
    int   busy_fall_cyc = 0;
    int   rise_cnt = 0;
    int   hold_cnt = 0;
    int   ack_delay = 1;
    int   busy_len = 3;
    bit   rand_uart = 0;
    bit   track = 0;
    logic [7:0] held_data = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference line built from a digit lookup string.
    task automatic push_line(input logic [15:0] s, input logic [1:0] c);
        string hexd = "0123456789ABCDEF";
`ifdef ADC_HEX_CHAN_PREFIX_EN
        exp_q.push_back("C");
        exp_q.push_back(hexd[int'(c)]);
        exp_q.push_back("=");
`endif
        for (int k = 3; k >= 0; k--) exp_q.push_back(hexd[int'(s[4*k +: 4])]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // One stimulus cycle; the model decides accept vs drop from ready as it stands this cycle.
    task automatic step(input bit v, input logic [15:0] s, input logic [1:0] c);
        i_sample_valid = v;
        i_sample = s;
        i_chan = c;
        if (v) begin
            if (o_sample_ready) push_line(s, c);
            else if (drops < DROP_MAX) drops++;
        end
        @(posedge i_clk); #1;
        i_sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int at_cyc);
        bit done = 0;
        at_cyc = 0;
        for (int i = 0; i < limit && !done; i++) begin
            if (o_sample_ready && exp_q.size() == 0 && !i_tx_busy && rise_cnt == 0) begin
                done = 1;
                at_cyc = cyc;
            end else begin
                step(1'b0, 16'h0000, 2'd0);
            end
        end
        chk("reached_idle", int'(done), 1);
    endtask

    task automatic wait_starts(input int target, input int limit);
        bit done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            if (start_cnt >= target) done = 1;
            else step(1'b0, 16'h0000, 2'd0);
        end
        chk("start_seen", int'(done), 1);
    endtask

    // Monitor and UART responder, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_tx_start) begin
                chk("single_start_per_byte", int'(i_tx_busy || rise_cnt > 0), 0);
                chk("start_has_expected_byte", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("tx_byte", int'(o_tx_data), int'(exp_q.pop_front()));
                start_cnt++;
                last_start_cyc = cyc;
                held_data = o_tx_data;
                track = 1;
            end else if (track) begin
                chk("tx_data_stable", int'(o_tx_data), int'(held_data));
            end
            if (i_rst) begin
                exp_q.delete();
                track = 0;
            end
            if (o_tx_start && !i_tx_busy && rise_cnt == 0)
                rise_cnt = rand_uart ? int'($urandom_range(1, 4)) : ack_delay;
            if (rise_cnt > 0) begin
                rise_cnt--;
                if (rise_cnt == 0) begin
                    i_tx_busy = 1'b1;
                    hold_cnt = rand_uart ? int'($urandom_range(1, 8)) : busy_len;
                end
            end else if (i_tx_busy) begin
                hold_cnt--;
                if (hold_cnt <= 0) begin
                    i_tx_busy = 1'b0;
                    busy_fall_cyc = cyc;
                    track = 0;
                end
            end
        end
    end

    initial begin
        int a;
        int t;
        int st0;

        // Reset values
        @(posedge i_clk); #1;
        chk("reset_ready", int'(o_sample_ready), 0);
        chk("reset_tx_start", int'(o_tx_start), 0);
        chk("reset_tx_data", int'(o_tx_data), 0);
        chk("reset_drop_cnt", int'(o_drop_cnt), 0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("ready_after_reset", int'(o_sample_ready), 1);

        // Single line, latency and ready timing
        st0 = start_cnt;
        a = cyc;
        step(1'b1, 16'h1A2F, 2'd0);
        wait_starts(st0 + 1, 50);
        chk("first_start_latency", last_start_cyc - a, 3);
        wait_idle(500, t);
        chk("ready_after_last_fall", t - busy_fall_cyc, 1);
        chk("starts_per_line", start_cnt - st0, LINE_LEN);

        // Extreme values and every nibble value
        step(1'b1, 16'h0000, 2'd1);
        wait_idle(500, t);
        step(1'b1, 16'hFFFF, 2'd3);
        wait_idle(500, t);
        for (int n = 0; n < 16; n++) begin
            step(1'b1, {4{4'(n)}} ^ 16'h0F00, 2'(n));
            wait_idle(500, t);
        end

        // Drops during a long line, saturating counter
        busy_len = 60;
        step(1'b1, 16'h1357, 2'd1);
        step(1'b1, 16'h2468, 2'd2);
        chk("drop_after_one", int'(o_drop_cnt), drops);
        for (int i = 0; i < 300; i++) step(1'b1, 16'($urandom), 2'($urandom));
        step(1'b0, 16'h0000, 2'd0);
        chk("drop_saturated", int'(o_drop_cnt), drops);
        wait_idle(5000, t);
        busy_len = 3;

        // Reset after the second byte is acknowledged
        st0 = start_cnt;
        step(1'b1, 16'hBEEF, 2'd0);
        wait_starts(st0 + 2, 200);
        for (int i = 0; i < 20 && !i_tx_busy; i++) step(1'b0, 16'h0000, 2'd0);
        i_rst = 1'b1;
        drops = 0;
        @(posedge i_clk); #1;
        chk("reset_cycle_ready", int'(o_sample_ready), 0);
        chk("reset_cycle_drop", int'(o_drop_cnt), 0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("ready_cycle_after_reset", int'(o_sample_ready), 1);
        st0 = start_cnt;
        for (int i = 0; i < 60; i++) step(1'b0, 16'h0000, 2'd0);
        chk("no_start_after_reset", start_cnt - st0, 0);
        wait_idle(500, t);
        step(1'b1, 16'h4C7D, 2'd2);
        wait_idle(500, t);
        chk("line_after_reset", start_cnt - st0, LINE_LEN);

        // Slow acknowledge
        ack_delay = 5;
        st0 = start_cnt;
        step(1'b1, 16'h9E06, 2'd1);
        wait_idle(1000, t);
        step(1'b1, 16'h5AC3, 2'd3);
        wait_idle(1000, t);
        chk("slow_ack_starts", start_cnt - st0, 2 * LINE_LEN);
        ack_delay = 1;

`ifdef ADC_HEX_CHAN_PREFIX_EN
        step(1'b1, 16'h8001, 2'd2);
        wait_idle(500, t);
`endif

        // Random traffic against a random UART
        rand_uart = 1;
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 11) == 0, 16'($urandom), 2'($urandom));
        wait_idle(3000, t);
        chk("drop_random", int'(o_drop_cnt), drops);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
